// File: rtl/zone_req_arbiter.sv
// Round-robin arbiter for the six irrigation zones: grants one zone at a time
// as a registered select code, with min/max dwell and a closed-valve guard gap.
module zone_req_arbiter #(
   parameter int MIN_DWELL = 4,
   parameter int MAX_DWELL = 16,
   parameter int GUARD     = 2,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [5:0] req,
   output logic [2:0] S,
   output logic       grant_valid,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GUARD = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] MIN_M1   = CNT_W'(MIN_DWELL - 1);
   localparam logic [CNT_W-1:0] MAX_M1   = CNT_W'(MAX_DWELL - 1);
   localparam logic [CNT_W-1:0] GUARD_M1 = CNT_W'(GUARD - 1);

   state_t           state, state_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [2:0]       ptr, ptr_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       s_nxt;

   logic             found;
   logic [2:0]       pick;
   logic [2:0]       k;
   logic [5:0]       others;
   logic             release_now;

   function automatic logic [2:0] wrap_inc(input logic [2:0] v);
      return (v == 3'd5) ? 3'd0 : v + 3'd1;
   endfunction

   // Search ptr+1, ptr+2, ... so the last granted zone is looked at last.
   always_comb begin
      found = 1'b0;
      pick  = 3'd0;
      k     = ptr;
      for (int i = 0; i < 6; i++) begin
         k = wrap_inc(k);
         if (!found && req[k]) begin
            found = 1'b1;
            pick  = k;
         end
      end
   end

   always_comb begin
      others      = req & ~(6'b000001 << idx);
      release_now = !en
                    || (cnt >= MIN_M1 && !req[idx])
                    || (cnt >= MAX_M1 && others != 6'b000000);
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      s_nxt     = 3'b000;
      case (state)
         ST_IDLE: begin
            if (en && found) begin
               state_nxt = ST_GRANT;
               idx_nxt   = pick;
               ptr_nxt   = pick;
               cnt_nxt   = '0;
               s_nxt     = pick + 3'd1;
            end
         end
         ST_GRANT: begin
            s_nxt = idx + 3'd1;
            if (release_now) begin
               state_nxt = ST_GUARD;
               cnt_nxt   = '0;
               s_nxt     = 3'b000;
            end else if (cnt < MAX_M1) begin
               // Saturate so a long uncontested grant never wraps below MIN_DWELL.
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_GUARD: begin
            if (cnt == GUARD_M1) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         idx         <= 3'd0;
         ptr         <= 3'd5;
         cnt         <= '0;
         S           <= 3'b000;
         grant_valid <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         ptr         <= ptr_nxt;
         cnt         <= cnt_nxt;
         S           <= s_nxt;
         grant_valid <= (s_nxt != 3'b000);
         busy        <= (state_nxt != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_zone_req_arbiter.sv
// Bench for zone_req_arbiter: reset checks, hand-computed vector table,
// directed multi-cycle sequences, and random traffic against a zone-level model.
module tb_zone_req_arbiter;

   localparam int MIN_DWELL = 4;
   localparam int MAX_DWELL = 16;
   localparam int GUARD     = 2;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [5:0] req;
   logic [2:0] S;
   logic       grant_valid;
   logic       busy;

   int n_total = 0;
   int n_pass  = 0;

   // Expected {busy, grant_valid, S} after each clock edge.
   logic [4:0] exp_q[$];

   zone_req_arbiter #(
      .MIN_DWELL(MIN_DWELL),
      .MAX_DWELL(MAX_DWELL),
      .GUARD(GUARD),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .req(req),
      .S(S),
      .grant_valid(grant_valid),
      .busy(busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Zone-level view: which zone is open (-1 none), how long it has been open,
   // how many closed guard cycles remain, and which zone was served last.
   int m_zone, m_age, m_gap, m_last;

   function automatic void model_reset();
      m_zone = -1;
      m_age  = 0;
      m_gap  = 0;
      m_last = 5;
   endfunction

   function automatic void model_step(input logic e, input logic [5:0] r);
      logic [5:0] others;
      logic [2:0] s_exp;
      bit         rel;
      if (m_zone >= 0) begin
         others = r & ~(6'b000001 << m_zone);
         rel = !e || (m_age >= MIN_DWELL && !r[m_zone])
                  || (m_age >= MAX_DWELL && others != 6'b0);
         if (rel) begin
            m_zone = -1;
            m_gap  = GUARD;
         end else begin
            m_age++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (e && r != 6'b0) begin
         for (int i = 1; i <= 6; i++) begin
            int z;
            z = (m_last + i) % 6;
            if (r[z]) begin
               m_zone = z;
               m_last = z;
               m_age  = 1;
               break;
            end
         end
      end
      s_exp = (m_zone >= 0) ? 3'(m_zone + 1) : 3'b000;
      exp_q.push_back({(m_zone >= 0 || m_gap > 0), (m_zone >= 0), s_exp});
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got busy/valid/S=%b required %b at %0t", name, act, expv, $time);
   endtask

   task automatic chk1(input string name, input int act, input int expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d required %0d at %0t", name, act, expv, $time);
   endtask

   // ---------------- driver ----------------
   // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
   task automatic step(input logic e, input logic [5:0] r, input string name,
                       input bit use_tab, input logic [4:0] tab);
      logic [4:0] m;
      en  = e;
      req = r;
      @(posedge clk);
      model_step(e, r);
      #1;
      m = exp_q.pop_front();
      if (use_tab) chk(name, {busy, grant_valid, S}, tab);
      else         chk(name, {busy, grant_valid, S}, m);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (busy && n < 40) begin
         step(1'b1, 6'b0, name, 1'b0, 5'b0);
         n++;
      end
      if (busy) chk1({name, "_timeout"}, 1, 0);
   endtask

   typedef struct {
      logic       e;
      logic [5:0] r;
      logic [4:0] expv;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(input logic e, input logic [5:0] r, input logic [2:0] s,
                                   input logic v, input logic b, input int n);
      vec_t t;
      t.e = e; t.r = r; t.expv = {b, v, s};
      for (int i = 0; i < n; i++) vecs.push_back(t);
   endfunction

   // ---------------- stimulus ----------------
   logic [2:0] seg_s[$];
   int         seg_n[$];

   initial begin
      logic [2:0] prev_s;
      int         run;
      logic [5:0] rr;
      logic       re;

      // Single zone 2 held 10 cycles, then guard; then a 1-cycle pulse on zone 3.
      add_vec(1'b1, 6'b000100, 3'b011, 1'b1, 1'b1, 10);
      add_vec(1'b1, 6'b000000, 3'b000, 1'b0, 1'b1, 2);
      add_vec(1'b1, 6'b000000, 3'b000, 1'b0, 1'b0, 2);
      add_vec(1'b1, 6'b001000, 3'b100, 1'b1, 1'b1, 1);
      add_vec(1'b1, 6'b000000, 3'b100, 1'b1, 1'b1, 3);
      add_vec(1'b1, 6'b000000, 3'b000, 1'b0, 1'b1, 2);
      add_vec(1'b1, 6'b000000, 3'b000, 1'b0, 1'b0, 1);

      // Reset with every zone requesting.
      rst_n = 1'b0;
      en    = 1'b1;
      req   = 6'b111111;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {busy, grant_valid, S}, 5'b00000);
      rst_n = 1'b1;
      step(1'b1, 6'b111111, "reset_first_grant", 1'b1, 5'b11001);
      drain("reset_drain");

      // The single-zone and short-pulse table starts from IDLE with ptr=0,
      // so zone 2 and then zone 3 are the only candidates anyway.
      foreach (vecs[i]) step(vecs[i].e, vecs[i].r, $sformatf("vec%0d", i), 1'b1, vecs[i].expv);

      // Round-robin between zones 0 and 5 under constant demand.
      prev_s = S;
      run    = 0;
      for (int i = 0; i < 60; i++) begin
         step(1'b1, 6'b100001, "rr_model", 1'b0, 5'b0);
         if (S == prev_s) run++;
         else begin
            if (run > 0) begin
               seg_s.push_back(prev_s);
               seg_n.push_back(run);
            end
            prev_s = S;
            run    = 1;
         end
      end
      chk1("rr_segments", (seg_s.size() >= 5) ? 1 : 0, 1);
      if (seg_s.size() >= 5) begin
         chk1("rr_seg0_zone", int'(seg_s[0]), 6);
         chk1("rr_seg0_len",  seg_n[0], MAX_DWELL);
         chk1("rr_seg1_gap",  seg_n[1], GUARD + 1);
         chk1("rr_seg2_zone", int'(seg_s[2]), 1);
         chk1("rr_seg2_len",  seg_n[2], MAX_DWELL);
         chk1("rr_seg3_gap",  seg_n[3], GUARD + 1);
         chk1("rr_seg4_zone", int'(seg_s[4]), 6);
      end
      drain("rr_drain");

      // Enable drops on the second grant cycle.
      step(1'b1, 6'b000001, "en_grant", 1'b0, 5'b0);
      chk1("en_grant_s", int'(S), 1);
      step(1'b1, 6'b000001, "en_hold", 1'b0, 5'b0);
      step(1'b0, 6'b000001, "en_drop", 1'b0, 5'b0);
      chk("en_drop_closed", {busy, grant_valid, S}, 5'b10000);
      for (int i = 0; i < 6; i++) step(1'b0, 6'b111111, "en_off", 1'b0, 5'b0);
      chk("en_off_idle", {busy, grant_valid, S}, 5'b00000);

      // Async reset in the middle of a zone 4 grant.
      step(1'b1, 6'b010000, "ar_grant", 1'b0, 5'b0);
      chk1("ar_grant_s", int'(S), 5);
      step(1'b1, 6'b010000, "ar_hold", 1'b0, 5'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_immediate", {busy, grant_valid, S}, 5'b00000);
      model_reset();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 6'b111111, "ar_regrant", 1'b0, 5'b0);
      chk1("ar_regrant_s", int'(S), 1);

      // Random traffic against the model.
      rr = $urandom_range(0, 63);
      re = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) rr = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 11) == 0) re = ~re;
         step(re, rr, "rand", 1'b0, 5'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Absolute time limit in case something stalls.
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
      $fatal(1);
   end

endmodule
